// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared state type and PC helpers for the fetch address generator.
package fetch_pc_unit_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_pc_state_t;

    function automatic logic [63:0] next_fetch_block_pc(input logic [63:0] pc, input int unsigned fetch_bytes);
        logic [63:0] mask;
        mask = 64'(fetch_bytes) - 64'd1;
        return (pc & ~mask) + 64'(fetch_bytes);
    endfunction

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic int unsigned prio_idx(input logic [31:0] v);
        prio_idx = 0;
        for (int i = 31; i >= 0; i--)
            if (v[i]) prio_idx = unsigned'(i);
    endfunction
endpackage

// File: rtl/fetch_pc_unit_arbiter.sv
// redirect_priority_arbiter: combinational lowest-index-wins redirect select.
module redirect_priority_arbiter
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned NUM_REDIRECT = 3,
    parameter int unsigned PC_WIDTH     = 32
) (
    input  logic [NUM_REDIRECT-1:0]          valid_i,
    input  logic [NUM_REDIRECT*PC_WIDTH-1:0] pc_i,
    output logic [NUM_REDIRECT-1:0]          grant_o,
    output logic                             any_o,
    output logic [PC_WIDTH-1:0]              pc_o
);
    assign any_o   = |valid_i;
    assign grant_o = valid_i & (~valid_i + NUM_REDIRECT'(1));
    assign pc_o    = pc_i[prio_idx(32'(valid_i))*PC_WIDTH +: PC_WIDTH];
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-block PC generator with prioritised redirects and halt/start control.
// Define FETCH_PC_PERF_EN to add saturating redirect/stall counters and a redirect trace.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned FETCH_BYTES  = 8,
    parameter int unsigned NUM_REDIRECT = 3,
    parameter int unsigned SEQ_WIDTH    = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [PC_WIDTH-1:0]              i_init_pc,
    input  logic                             i_start,
    input  logic                             i_halt,
    input  logic [NUM_REDIRECT-1:0]          i_redir_valid,
    input  logic [NUM_REDIRECT*PC_WIDTH-1:0] i_redir_pc,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [PC_WIDTH-1:0]              o_pc,
    output logic [SEQ_WIDTH-1:0]             o_seq,
    output logic                             o_epoch,
    output logic [NUM_REDIRECT-1:0]          o_redir_src
`ifdef FETCH_PC_PERF_EN
    ,
    output logic [31:0]                      o_perf_redirects,
    output logic [31:0]                      o_perf_stalls
`endif
);
    fetch_pc_state_t         state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d, pc_adv, redir_pc;
    logic [SEQ_WIDTH-1:0]    seq_q, seq_d;
    logic                    epoch_q, epoch_d, redir_any, fire;
    logic [NUM_REDIRECT-1:0] src_q, src_d, redir_grant;

    redirect_priority_arbiter #(.NUM_REDIRECT(NUM_REDIRECT), .PC_WIDTH(PC_WIDTH)) u_arb (
        .valid_i (i_redir_valid),
        .pc_i    (i_redir_pc),
        .grant_o (redir_grant),
        .any_o   (redir_any),
        .pc_o    (redir_pc)
    );

    assign pc_adv = PC_WIDTH'(next_fetch_block_pc(64'(pc_q), FETCH_BYTES));
    assign fire   = o_valid & i_ready;

    // A redirect wins over both the handshake advance and halt.
    always_comb begin
        pc_d    = redir_any ? redir_pc : fire ? pc_adv : pc_q;
        seq_d   = redir_any ? '0 : fire ? seq_q + SEQ_WIDTH'(1) : seq_q;
        epoch_d = epoch_q ^ redir_any;
        src_d   = redir_any ? redir_grant : src_q;
        state_d = redir_any ? RUN
                : (state_q == RUN && i_halt) ? HALTED
                : (state_q == IDLE && i_start) ? RUN
                : state_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            pc_q    <= i_init_pc;
            seq_q   <= '0;
            epoch_q <= 1'b0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            seq_q   <= seq_d;
            epoch_q <= epoch_d;
            src_q   <= src_d;
        end
    end

    assign o_valid     = state_q == RUN;
    assign o_pc        = pc_q;
    assign o_seq       = seq_q;
    assign o_epoch     = epoch_q;
    assign o_redir_src = src_q;

`ifdef FETCH_PC_PERF_EN
    logic [31:0] redirects_q, stalls_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            redirects_q <= '0;
            stalls_q    <= '0;
        end else begin
            if (redir_any && !(&redirects_q)) redirects_q <= redirects_q + 32'd1;
            if (o_valid && !i_ready && !(&stalls_q)) stalls_q <= stalls_q + 32'd1;
            if (redir_any) $display("[PC] Redirect src %0d: %h", prio_idx(32'(i_redir_valid)), redir_pc);
        end
    end

    assign o_perf_redirects = redirects_q;
    assign o_perf_stalls    = stalls_q;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed vector table, wrap sequence and randomized model check for fetch_pc_unit.
module tb_fetch_pc_unit;
    localparam int FB = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n, start, halt, ready, valid, epoch;
    logic [31:0] init_pc, pc;
    logic [2:0]  rv, src;
    logic [31:0] rpc [3];
    logic [3:0]  seq;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_state;
    logic [31:0] m_pc;
    int          m_seq;
    logic        m_ep;
    logic [2:0]  m_src;

    typedef struct {
        logic        rst_n, start, halt, ready;
        logic [2:0]  rv;
        logic [31:0] rpc0, rpc1, rpc2;
        logic        ev;
        logic [31:0] epc;
        logic [3:0]  eseq;
        logic        eep;
        logic [2:0]  esrc;
    } vec_t;

    vec_t vecs [17];

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_init_pc     (init_pc),
        .i_start       (start),
        .i_halt        (halt),
        .i_redir_valid (rv),
        .i_redir_pc    ({rpc[2], rpc[1], rpc[0]}),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_pc          (pc),
        .o_seq         (seq),
        .o_epoch       (epoch),
        .o_redir_src   (src)
    );

    function automatic vec_t mk(logic r, logic st, logic h, logic rd, logic [2:0] v,
                                logic [31:0] p0, logic [31:0] p1, logic [31:0] p2,
                                logic ev, logic [31:0] epc, logic [3:0] es, logic ee, logic [2:0] esr);
        vec_t t;
        t.rst_n = r; t.start = st; t.halt = h; t.ready = rd; t.rv = v;
        t.rpc0 = p0; t.rpc1 = p1; t.rpc2 = p2;
        t.ev = ev; t.epc = epc; t.eseq = es; t.eep = ee; t.esrc = esr;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: next state computed from the rules, one step per clock.
    task automatic model_step();
        if (!rst_n) begin
            m_state = M_IDLE; m_pc = init_pc; m_seq = 0; m_ep = 1'b0; m_src = 3'b000;
        end else if (rv != 3'b000) begin
            int k = 0;
            while (!rv[k]) k++;
            m_pc = rpc[k]; m_ep = ~m_ep; m_seq = 0; m_src = 3'(1 << k); m_state = M_RUN;
        end else begin
            if (m_state == M_RUN && ready) begin
                longint unsigned blk = longint'(m_pc) / FB;
                m_pc = 32'((blk + 1) * FB);
                m_seq = (m_seq + 1) % 16;
            end
            if (m_state == M_RUN && halt) m_state = M_HALT;
            else if (m_state == M_IDLE && start) m_state = M_RUN;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; ready = 1'b1; rv = 3'b000;
        init_pc = 32'h1000; rpc[0] = '0; rpc[1] = '0; rpc[2] = '0;

        //            rst st h  rdy rv      rpc0      rpc1      rpc2      v  pc          seq ep src
        vecs[0]  = mk(0, 0, 0, 1, 3'b000, 0,        0,        0,        0, 32'h1000, 0, 0, 3'b000);
        vecs[1]  = mk(0, 0, 0, 1, 3'b000, 0,        0,        0,        0, 32'h1000, 0, 0, 3'b000);
        vecs[2]  = mk(1, 1, 0, 1, 3'b000, 0,        0,        0,        1, 32'h1000, 0, 0, 3'b000);
        vecs[3]  = mk(1, 0, 0, 1, 3'b000, 0,        0,        0,        1, 32'h1008, 1, 0, 3'b000);
        vecs[4]  = mk(1, 0, 0, 1, 3'b000, 0,        0,        0,        1, 32'h1010, 2, 0, 3'b000);
        vecs[5]  = mk(1, 0, 0, 0, 3'b000, 0,        0,        0,        1, 32'h1010, 2, 0, 3'b000);
        vecs[6]  = mk(1, 0, 0, 0, 3'b000, 0,        0,        0,        1, 32'h1010, 2, 0, 3'b000);
        vecs[7]  = mk(1, 0, 0, 0, 3'b000, 0,        0,        0,        1, 32'h1010, 2, 0, 3'b000);
        vecs[8]  = mk(1, 0, 0, 1, 3'b000, 0,        0,        0,        1, 32'h1018, 3, 0, 3'b000);
        vecs[9]  = mk(1, 0, 0, 1, 3'b110, 0,        32'h2004, 32'h3000, 1, 32'h2004, 0, 1, 3'b010);
        vecs[10] = mk(1, 0, 0, 1, 3'b000, 0,        0,        0,        1, 32'h2008, 1, 1, 3'b010);
        vecs[11] = mk(1, 0, 1, 1, 3'b000, 0,        0,        0,        0, 32'h2010, 2, 1, 3'b010);
        vecs[12] = mk(1, 1, 0, 1, 3'b000, 0,        0,        0,        0, 32'h2010, 2, 1, 3'b010);
        vecs[13] = mk(1, 0, 0, 1, 3'b001, 32'h80,   0,        0,        1, 32'h0080, 0, 0, 3'b001);
        vecs[14] = mk(1, 0, 1, 0, 3'b000, 0,        0,        0,        0, 32'h0080, 0, 0, 3'b001);
        vecs[15] = mk(0, 0, 0, 0, 3'b100, 0,        0,        32'h3000, 0, 32'h1000, 0, 0, 3'b000);
        vecs[16] = mk(1, 0, 0, 1, 3'b000, 0,        0,        0,        0, 32'h1000, 0, 0, 3'b000);

        for (int i = 0; i < 17; i++) begin
            rst_n = vecs[i].rst_n; start = vecs[i].start; halt = vecs[i].halt;
            ready = vecs[i].ready; rv = vecs[i].rv;
            rpc[0] = vecs[i].rpc0; rpc[1] = vecs[i].rpc1; rpc[2] = vecs[i].rpc2;
            tick();
            chk($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d pc", i),    pc,         vecs[i].epc);
            chk($sformatf("vec%0d seq", i),   32'(seq),   32'(vecs[i].eseq));
            chk($sformatf("vec%0d epoch", i), 32'(epoch), 32'(vecs[i].eep));
            chk($sformatf("vec%0d src", i),   32'(src),   32'(vecs[i].esrc));
        end

        // PC wraps at the top of the address space; seq wraps after 16 fires.
        rv = 3'b000; halt = 1'b0; ready = 1'b1; start = 1'b0;
        init_pc = 32'hFFFF_FFF0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("wrap pc0", pc, 32'hFFFF_FFF0);
        chk("wrap valid", 32'(valid), 32'd1);
        tick();
        chk("wrap pc1", pc, 32'hFFFF_FFF8);
        tick();
        chk("wrap pc2", pc, 32'h0000_0000);
        chk("wrap seq2", 32'(seq), 32'd2);
        for (int i = 0; i < 14; i++) tick();
        chk("wrap seq16", 32'(seq), 32'd0);
        chk("wrap pc16", pc, 32'h0000_0070);

        // Randomized run against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst_n = (c == 0) ? 1'b0 : ($urandom_range(63, 0) != 0);
            init_pc = $urandom;
            start = ($urandom_range(3, 0) == 0);
            halt  = ($urandom_range(15, 0) == 0);
            ready = ($urandom_range(3, 0) != 0);
            for (int k = 0; k < 3; k++) begin
                rv[k]  = ($urandom_range(7, 0) == 0);
                rpc[k] = $urandom;
            end
            model_step();
            tick();
            chk("rand valid", 32'(valid), 32'(m_state == M_RUN));
            chk("rand pc", pc, m_pc);
            chk("rand seq", 32'(seq), 32'(m_seq));
            chk("rand epoch", 32'(epoch), 32'(m_ep));
            chk("rand src", 32'(src), 32'(m_src));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Parametrised fetch-address generator; successor to the single-redirect PC register.
- Sits at the front of the fetch stage.
- Presents one fetch-block PC per cycle over a valid/ready handshake.
- Arbitrates N prioritised redirect sources, supports halt/start control, and tags each issued block with a sequence number and redirect epoch so downstream stages can drop stale fetches.

Parameters:
- PC_WIDTH, 32, width of program_counter_t.
- FETCH_BYTES, 8, bytes per fetch block; power of 2, ≥4.
- NUM_REDIRECT, 3, redirect sources; index 0 = highest priority (commit/exception), then branch, then predictor.
- SEQ_WIDTH, 4, width of per-block sequence tag.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_init_pc  in  PC_WIDTH  PC loaded while reset is asserted
- i_start  in  1  leave IDLE and begin fetching
- i_halt  in  1  stop issuing fetches (WFI/debug)
- i_redir_valid  in  NUM_REDIRECT  per-source redirect request
- i_redir_pc  in  NUM_REDIRECT*PC_WIDTH  per-source target; source k occupies bits [k*PC_WIDTH +: PC_WIDTH]
- o_valid  out  1  fetch request valid
- i_ready  in  1  fetch accepts request
- o_pc  out  PC_WIDTH  fetch PC; may be unaligned after a redirect
- o_seq  out  SEQ_WIDTH  sequence tag of o_pc
- o_epoch  out  1  redirect epoch of o_pc
- o_redir_src  out  NUM_REDIRECT  one-hot source that won the last redirect; zero after reset

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - state=IDLE, pc=i_init_pc, seq=0, epoch=0, o_redir_src=0.
  - o_valid=0.
  - All other inputs are ignored.
  - Reset asserted mid-operation aborts everything in the same cycle.
- States:
  - IDLE: o_valid=0. i_start → RUN.
  - RUN: o_valid=1.
  - HALTED: o_valid=0.
- Transitions, evaluated in priority order each cycle:
  - Any i_redir_valid → RUN, from every state.
  - Else i_halt in RUN → HALTED.
  - Else i_start in IDLE → RUN.
  - HALTED exits only by redirect; i_start is ignored there.
- Redirect:
  - Lowest asserted index k wins.
  - Next cycle: pc=i_redir_pc[k], epoch toggles, seq resets to 0, o_redir_src=one-hot(k).
  - Redirect overrides handshake advance and halt in the same cycle. The current o_pc, if accepted that cycle, is still consumed by fetch; fetch kills it via epoch.
- Sequential advance (fire = o_valid & i_ready, no redirect):
  - pc = (pc & ~(FETCH_BYTES-1)) + FETCH_BYTES, i.e. aligned down, then next block.
  - seq = seq+1, modulo 2^SEQ_WIDTH.
  - PC wraps modulo 2^PC_WIDTH, so 0xFFFF_FFF8 → 0x0000_0000.
- Stall (o_valid & ~i_ready): pc, seq and epoch hold; o_pc stays stable until accepted.
- Halt while i_ready=0: halt takes effect anyway. The unaccepted PC is kept and is re-presented only after a redirect loads a new PC.
- Latency:
  - Redirect to o_pc update: 1 cycle.
  - i_start to o_valid: 1 cycle.
  - Reset release to IDLE: immediate.

Optional Feature:
- Macro FETCH_PC_PERF_EN.
- Defined:
  - Adds ports o_perf_redirects (32, out) and o_perf_stalls (32, out).
  - o_perf_redirects counts redirect-taking cycles; o_perf_stalls counts o_valid & ~i_ready cycles.
  - Both saturate at 0xFFFF_FFFF and reset to 0.
  - Each redirect also emits $display("[PC] Redirect src %0d: %h", k, pc).
- Undefined: no counters, no ports, no display; functional behaviour is identical.

Decomposition:
- include/pc.svh gains:
  - fetch_pc_state_t enum (IDLE, RUN, HALTED).
  - FETCH_BYTES-parameterised align-and-advance function next_fetch_block_pc.
  - A priority-encode helper.
- One sub-module: redirect_priority_arbiter.
  - Combinational; lowest-index-wins.
  - Outputs one-hot grant, any-valid, and selected PC.
  - Parameterised by NUM_REDIRECT and PC_WIDTH.

Test Plan:
- Reset with i_init_pc=0x1000, i_start pulse, i_ready=1 → o_valid rises 1 cycle after start; o_pc = 0x1000, 0x1008, 0x1010; o_seq = 0, 1, 2; o_epoch=0.
- i_ready=0 for 3 cycles at o_pc=0x1010 → o_pc/o_seq held for 3 cycles; advances to 0x1018 on first ready cycle.
- Simultaneous redirects src1=0x2004 and src2=0x3000 → next cycle o_pc=0x2004, o_epoch=1, o_seq=0, o_redir_src=3'b010; following o_pc=0x2008.
- i_init_pc=0xFFFF_FFF0, continuous accept → o_pc = 0xFFFF_FFF0, 0xFFFF_FFF8, 0x0000_0000; o_seq wraps 15→0 after 16 fires.
- i_halt in RUN → o_valid=0 next cycle; i_start ignored; src0 redirect to 0x80 → RUN, o_pc=0x80, epoch toggled.
- Reset asserted mid-stream with a redirect pending → next cycle IDLE, o_valid=0, pc=i_init_pc, epoch=0, redirect discarded.
